mem_arbiter: RTL

Shares one single-ported `memory` instance (combinational read, write on `posedge clk`) between two requesters. Port 0 is the data load/store unit. Port 1 is instruction fetch.
Grants at most one request per cycle, round-robin, with an optional lock for back-to-back atomic sequences. Drives the memory's read/write address, data and enable. Returns registered read data and write acknowledges one cycle after acceptance.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_rr.sv | 31 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam int NUM_PORTS  = 2;
   localparam int PORT_DATA  = 0;
   localparam int PORT_FETCH = 1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: among the unmasked valid ports, ptr breaks ties.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] valid,
   input  logic                 ptr,
   input  logic [NUM_PORTS-1:0] mask,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 granted,
   output logic                 grant_idx
);

   logic [NUM_PORTS-1:0] eligible;

   always_comb begin
      eligible  = valid & mask;
      granted   = |eligible;
      grant_idx = 1'b0;
      grant     = '0;
      case (eligible)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ptr;
         default: grant_idx = 1'b0;
      endcase
      if (granted) begin
         grant = grant_idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the load/store unit (port 0) and
// instruction fetch (port 1); one grant per cycle, round-robin with optional lock.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BIT_WIDTH   = 32,
   parameter int ENTRY_COUNT = 1024,
   parameter int ADDR_WIDTH  = $clog2(ENTRY_COUNT)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_we,
   input  logic [NUM_PORTS-1:0]            req_lock,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*BIT_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]            rsp_valid,
   output logic [BIT_WIDTH-1:0]            rsp_rdata,
   output logic [ADDR_WIDTH-1:0]           mem_readAddr,
   output logic [ADDR_WIDTH-1:0]           mem_writeAddr,
   output logic [BIT_WIDTH-1:0]            mem_writeData,
   output logic                            mem_writeEn,
   input  logic [BIT_WIDTH-1:0]            mem_readData
);

   arb_state_e           state, state_next;
   logic                 lock_owner, lock_owner_next;
   logic                 rr_ptr, rr_ptr_next;
   logic [NUM_PORTS-1:0] mask, grant;
   logic                 granted, g;
   logic                 sel_we;

   rr_arbiter2 u_rr (
      .valid     (req_valid),
      .ptr       (rr_ptr),
      .mask      (mask),
      .grant     (grant),
      .granted   (granted),
      .grant_idx (g)
   );

   // Reset suppresses every grant; a lock restricts eligibility to its owner.
   always_comb begin
      mask = 2'b11;
      if (rst) begin
         mask = 2'b00;
      end else if (state == LOCKED) begin
         mask = lock_owner ? 2'b10 : 2'b01;
      end
   end

   // With no grant g is 0, so the memory sees port 0's fields and no write.
   always_comb begin
      req_ready     = grant;
      sel_we        = req_we[g];
      mem_readAddr  = g ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      mem_writeAddr = mem_readAddr;
      mem_writeData = g ? req_wdata[2*BIT_WIDTH-1:BIT_WIDTH] : req_wdata[BIT_WIDTH-1:0];
      mem_writeEn   = granted & sel_we;
   end

   always_comb begin
      state_next      = state;
      lock_owner_next = lock_owner;
      rr_ptr_next     = rr_ptr;
      case (state)
         ARB: begin
            if (granted) begin
               rr_ptr_next = ~g;
               if (req_lock[g]) begin
                  state_next      = LOCKED;
                  lock_owner_next = g;
               end
            end
         end
         LOCKED: begin
            if (granted && !req_lock[g]) begin
               state_next = ARB;
            end
         end
         default: state_next = ARB;
      endcase
   end

   // Responses are one-cycle pulses; writes report zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB;
         lock_owner <= 1'b0;
         rr_ptr     <= 1'b0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
      end else begin
         state      <= state_next;
         lock_owner <= lock_owner_next;
         rr_ptr     <= rr_ptr_next;
         rsp_valid  <= grant;
         if (granted) begin
            rsp_rdata <= sel_we ? '0 : mem_readData;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (ENTRY_COUNT >= (1 << ADDR_WIDTH))
            else $error("ENTRY_COUNT smaller than the address space");
      end
   end

endmodule
